reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 Parameter SETUP_CYCLES, default 1, legal 1..4, cycles the address/data are stable before a strobe rises.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_wr  in  1  1 = write, 0 = read pair.
REQ-009 req_waddr / req_wdata  in  ADDR_W / DATA_W  write target and data.
REQ-010 req_raddr1 / req_raddr2  in  ADDR_W each  read pair addresses.
REQ-011 rsp_valid  out  1  response present; held until rsp_ready.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_data1 / rsp_data2  out  DATA_W each  captured read data (reads only).
REQ-014 rsp_err  out  1  write read-back mismatch (verify builds only).
REQ-015 rf_write_en / rf_read_en  out  1 each  register-file strobes, rising-edge active.
REQ-016 rf_write_addr, rf_read1_addr, rf_read2_addr, rf_write_data  out  register-file address/data buses.
REQ-017 rf_read1_data / rf_read2_data  in  DATA_W each  register-file read results.

Function
REQ-018 Handshake: a request SHALL be accepted on a clock edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance all request fields SHALL be registered; the rf_* address/data buses SHALL be driven from those registers and held constant until the controller returns to IDLE.
REQ-020 FSM states: IDLE, SETUP, STROBE, RELEASE, CAPTURE, RESP; a per-transaction phase flag selects write or read.
REQ-021 IDLE -> SETUP on accept; SETUP lasts SETUP_CYCLES cycles (down-counter); SETUP -> STROBE; STROBE -> RELEASE after exactly 1 cycle.
REQ-022 rf_write_en SHALL be 1 only in STROBE of a write phase; rf_read_en only in STROBE of a read phase; both SHALL be registered outputs, never 1 simultaneously, never glitch.
REQ-023 Read phase: RELEASE -> CAPTURE; in CAPTURE rf_read1_data/rf_read2_data SHALL be registered into rsp_data1/rsp_data2; CAPTURE -> RESP.
REQ-024 Write phase without verify: RELEASE -> RESP; rsp_data1/rsp_data2 retain previous values.
REQ-025 RESP SHALL assert rsp_valid; RESP -> IDLE on the edge where rsp_ready = 1; rsp_data*/rsp_err held stable while rsp_valid = 1.
REQ-026 Latency (SETUP_CYCLES = 1, accept at edge T): read rsp_valid first high after edge T+5; write rsp_valid first high after edge T+4.
REQ-027 Back-to-back: a new request SHALL NOT be accepted in the same cycle rsp_valid drops; req_ready rises the cycle after RESP exits.
REQ-028 req_valid SHALL be ignored outside IDLE; fields changing outside IDLE SHALL have no effect.
REQ-029 Address equality (raddr1 = raddr2) SHALL require no special handling; both captures return the same register.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, rf_write_en = 0, rf_read_en = 0, rsp_valid = 0, rsp_err = 0, rsp_data1/2 = 0, rf_* buses = 0, SETUP counter = 0.
REQ-031 req_ready SHALL be 0 while rst_n = 0 and 1 from the first edge after release.
REQ-032 Reset mid-transaction SHALL abort it with no response; a strobe active at reset SHALL fall asynchronously.

Configuration
REQ-033 Macro RFC_WRITE_VERIFY_EN: when defined, a write SHALL continue after write RELEASE into a read phase (SETUP, STROBE, RELEASE, CAPTURE) with rf_read1_addr = rf_read2_addr = write address.
REQ-034 With RFC_WRITE_VERIFY_EN, CAPTURE SHALL set rsp_err = 1 if rf_read1_data != registered write data, else 0; rsp_data1/2 SHALL take the read-back value; write latency becomes rsp_valid after edge T+8.
REQ-035 Without RFC_WRITE_VERIFY_EN, rsp_err SHALL be tied 0 and no read-back occurs.

Verification
REQ-036 Write addr 3 data 0xA5, then read 3/3 -> rsp_data1 = rsp_data2 = 0xA5; rf_write_en high exactly 1 cycle, rsp_valid after edge T+4.
REQ-037 Writes r0 = 0x11, r15 = 0xEE, then read 0/15 -> rsp_data1 = 0x11, rsp_data2 = 0xEE, rsp_valid after edge T+5.
REQ-038 Hold rsp_ready = 0 for 10 cycles -> rsp_valid and data stable, req_ready = 0, second req_valid ignored.
REQ-039 Assert rst_n = 0 while rf_write_en = 1 -> strobe falls without clock, no response, register-file untouched by later edges.
REQ-040 SETUP_CYCLES = 4 -> addresses stable 4 cycles before strobe; read latency 8 edges.
REQ-041 RFC_WRITE_VERIFY_EN with register-file model forced to return 0x00 -> write 0x5A to r7 yields rsp_err = 1, rsp_data1 = 0x00.

Source files
------------

// File: rtl/reg_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_access_ctrl_if
// Request/response bundle between a requester and reg_access_ctrl.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once valid is raised it stays high, with its payload unchanged, until
//   that transfer edge. ready may be raised or lowered at any time and does
//   not depend on valid combinationally.
//
// Signals
//   req_valid/req_ready : request channel handshake
//   req_wr              : 1 = write, 0 = read pair
//   req_waddr/req_wdata : write target and data
//   req_raddr1/2        : read pair addresses
//   rsp_valid/rsp_ready : response channel handshake
//   rsp_data1/2         : captured read data
//   rsp_err             : write read-back mismatch (verify builds only)
//
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface reg_access_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_waddr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] req_raddr1;
  logic [ADDR_W-1:0] req_raddr2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_waddr, req_wdata, req_raddr1, req_raddr2,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_waddr, req_wdata, req_raddr1, req_raddr2,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2, rsp_err
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// reg_access_ctrl
// Sequences single register-file accesses: a write, or a read of two
// registers. Each access walks SETUP (address/data settle for SETUP_CYCLES
// cycles) -> STROBE (one-cycle registered strobe) -> RELEASE, then a read
// captures the register-file outputs in CAPTURE and the result is offered
// in RESP until the requester takes it.
//
// Optional feature (macro RFC_WRITE_VERIFY_EN): every write is followed by
// a read-back of the written register; rsp_err flags a mismatch and
// rsp_data1/2 carry the read-back value. Without the macro rsp_err is 0.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : request/response channels (reg_access_ctrl_if)
//   rf_write_en         : write strobe, high only in STROBE of a write phase
//   rf_read_en          : read strobe, high only in STROBE of a read phase
//   rf_write_addr/data  : write address/data bus
//   rf_read1/2_addr     : read address buses
//   rf_read1/2_data     : register-file read results
//   dbg_state           : current FSM state encoding
//
// Parameters: DATA_W, ADDR_W, SETUP_CYCLES (1..4).
//
// Timing (SETUP_CYCLES = 1, accept at edge T): the FSM reaches RESP at
// T+4 for reads and T+3 for writes; rsp_valid is a registered output raised
// on the following edge, so it is first high after T+5 / T+4.
// ---------------------------------------------------------------------------
module reg_access_ctrl #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_access_ctrl_if.slave  bus,
  output logic              rf_write_en,
  output logic              rf_read_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [ADDR_W-1:0] rf_read1_addr,
  output logic [ADDR_W-1:0] rf_read2_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read1_data,
  input  logic [DATA_W-1:0] rf_read2_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // Counter is loaded with SETUP_CYCLES-1 so SETUP lasts SETUP_CYCLES cycles.
  localparam logic [2:0] SETUP_LOAD = 3'(SETUP_CYCLES - 1);

  state_t            state, state_nxt;
  logic              phase_rd, phase_rd_nxt;   // 1 = current phase is a read
  logic [2:0]        setup_cnt, setup_cnt_nxt;
  logic              accept;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data2_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;
  assign dbg_state     = state;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    phase_rd_nxt  = phase_rd;
    setup_cnt_nxt = setup_cnt;
    accept        = 1'b0;
    case (state)
      S_IDLE: begin
        // req_ready is low during the first cycle after reset release, so
        // gating on it keeps that cycle from accepting.
        if (req_ready_q && bus.req_valid) begin
          accept        = 1'b1;
          state_nxt     = S_SETUP;
          phase_rd_nxt  = ~bus.req_wr;
          setup_cnt_nxt = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (setup_cnt == 3'd0) begin
          state_nxt = S_STROBE;
        end else begin
          setup_cnt_nxt = setup_cnt - 3'd1;
        end
      end
      S_STROBE: begin
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (phase_rd) begin
          state_nxt = S_CAPTURE;
        end else begin
`ifdef RFC_WRITE_VERIFY_EN
          // Write done: read the same register back before responding.
          state_nxt     = S_SETUP;
          phase_rd_nxt  = 1'b1;
          setup_cnt_nxt = SETUP_LOAD;
`else
          state_nxt = S_RESP;
`endif
        end
      end
      S_CAPTURE: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and registered control outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase_rd    <= 1'b0;
      setup_cnt   <= 3'd0;
      req_ready_q <= 1'b0;
      rf_write_en <= 1'b0;
      rf_read_en  <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_rd    <= phase_rd_nxt;
      setup_cnt   <= setup_cnt_nxt;
      req_ready_q <= (state_nxt == S_IDLE);
      // Strobes decoded from the next state so they are flop outputs that
      // line up exactly with the STROBE cycle.
      rf_write_en <= (state_nxt == S_STROBE) && !phase_rd_nxt;
      rf_read_en  <= (state_nxt == S_STROBE) &&  phase_rd_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Request field registers: rf_* buses hold these for the whole access.
  // -------------------------------------------------------------------------
`ifdef RFC_WRITE_VERIFY_EN
  logic wr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_read1_addr <= '0;
      rf_read2_addr <= '0;
`ifdef RFC_WRITE_VERIFY_EN
      wr_q          <= 1'b0;
`endif
    end else if (accept) begin
      rf_write_addr <= bus.req_waddr;
      rf_write_data <= bus.req_wdata;
`ifdef RFC_WRITE_VERIFY_EN
      wr_q          <= bus.req_wr;
      // The read-back phase reads the write target on both ports.
      rf_read1_addr <= bus.req_wr ? bus.req_waddr : bus.req_raddr1;
      rf_read2_addr <= bus.req_wr ? bus.req_waddr : bus.req_raddr2;
`else
      rf_read1_addr <= bus.req_raddr1;
      rf_read2_addr <= bus.req_raddr2;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Response path
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
    end else if (rsp_valid_q) begin
      if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end else if (state == S_RESP) begin
      rsp_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else if (state == S_CAPTURE) begin
      rsp_data1_q <= rf_read1_data;
      rsp_data2_q <= rf_read2_data;
    end
  end

`ifdef RFC_WRITE_VERIFY_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (state == S_CAPTURE) begin
      // Plain reads always report no error.
      rsp_err_q <= wr_q && (rf_read1_data != rf_write_data);
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_access_ctrl
// Directed bench for reg_access_ctrl. Two instances: dut (SETUP_CYCLES = 1)
// carries most traffic, dut4 (SETUP_CYCLES = 4) checks the longer setup.
// A behavioural register-file array answers both instances. The reference
// model tracks register contents and last response data at transaction
// level and queues the expected response of each accepted request.
// ---------------------------------------------------------------------------
module tb_reg_access_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = 2 * DW + 1;   // {err, data1, data2}

`ifdef RFC_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int WR_LAT = 8;
`else
  localparam bit VERIFY = 1'b0;
  localparam int WR_LAT = 4;
`endif
  localparam int RD_LAT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  reg_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();

  logic          rf_we, rf_re, rf_we4, rf_re4;
  logic [AW-1:0] rf_wa, rf_a1, rf_a2, rf_wa4, rf_a1_4, rf_a2_4;
  logic [DW-1:0] rf_wd, rf_d1, rf_d2, rf_wd4, rf_d1_4, rf_d2_4;
  logic [2:0]    dbg, dbg4;

  reg_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SETUP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .rf_write_en(rf_we), .rf_read_en(rf_re),
    .rf_write_addr(rf_wa), .rf_read1_addr(rf_a1), .rf_read2_addr(rf_a2),
    .rf_write_data(rf_wd), .rf_read1_data(rf_d1), .rf_read2_data(rf_d2),
    .dbg_state(dbg)
  );

  reg_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SETUP_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .rf_write_en(rf_we4), .rf_read_en(rf_re4),
    .rf_write_addr(rf_wa4), .rf_read1_addr(rf_a1_4), .rf_read2_addr(rf_a2_4),
    .rf_write_data(rf_wd4), .rf_read1_data(rf_d1_4), .rf_read2_data(rf_d2_4),
    .dbg_state(dbg4)
  );

  // ---------------- behavioural register file ----------------
  logic [DW-1:0] rf_mem [16];
  bit            rf_clear;
  bit            force_zero;

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'(i * 3);
    end else if (rf_we) begin
      rf_mem[rf_wa] <= rf_wd;
    end
  end

  assign rf_d1   = force_zero ? '0 : rf_mem[rf_a1];
  assign rf_d2   = force_zero ? '0 : rf_mem[rf_a2];
  assign rf_d1_4 = rf_mem[rf_a1_4];
  assign rf_d2_4 = rf_mem[rf_a2_4];

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0]  exp_q [$];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] last_d1, last_d2;
  int we_cyc = 0, re_cyc = 0, we4_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    last_d1 = '0;
    last_d2 = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input bit wr, input logic [3:0] wa,
                              input logic [7:0] wd, input logic [3:0] a1,
                              input logic [3:0] a2);
    logic [DW-1:0] rb;
    if (wr) begin
      exp_mem[wa] = wd;
      if (VERIFY) begin
        rb      = force_zero ? 8'h00 : wd;
        last_d1 = rb;
        last_d2 = rb;
        exp_q.push_back({rb != wd, rb, rb});
      end else begin
        exp_q.push_back({1'b0, last_d1, last_d2});
      end
    end else begin
      last_d1 = force_zero ? 8'h00 : exp_mem[a1];
      last_d2 = force_zero ? 8'h00 : exp_mem[a2];
      exp_q.push_back({1'b0, last_d1, last_d2});
    end
  endtask

  // Compare process: sampled on the falling edge, away from DUT updates.
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_rsp;
  logic [W-1:0] cur_rsp;
  logic [W-1:0] exp_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("strobe_exclusive", {31'd0, rf_we & rf_re}, 32'd0);
      if (rf_we) we_cyc++;
      if (rf_re) re_cyc++;
      if (rf_we4) we4_cyc++;
      cur_rsp = {bus.rsp_err, bus.rsp_data1, bus.rsp_data2};
      if (bus.rsp_valid) begin
        if (prev_hold) check("rsp_stable", 32'(cur_rsp), 32'(prev_rsp));
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            exp_rsp = exp_q.pop_front();
            check("rsp_payload", 32'(cur_rsp), 32'(exp_rsp));
          end
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp  = cur_rsp;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input bit wr, input logic [3:0] wa, input logic [7:0] wd,
                      input logic [3:0] a1, input logic [3:0] a2,
                      input int exp_lat, input int hold);
    int n;
    int we0, re0;
    bit bus_ok;
    logic [3:0] ea1, ea2;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_wait", {31'd0, n < 40}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_wr     = wr;
    bus.req_waddr  = wa;
    bus.req_wdata  = wd;
    bus.req_raddr1 = a1;
    bus.req_raddr2 = a2;
    we0 = we_cyc;
    re0 = re_cyc;
    @(posedge clk);                         // accept edge T
    model_accept(wr, wa, wd, a1, a2);
    #1;
    // Scribble the fields: nothing after acceptance may affect the access.
    bus.req_valid  = 1'b0;
    bus.req_wr     = ~wr;
    bus.req_waddr  = ~wa;
    bus.req_wdata  = ~wd;
    bus.req_raddr1 = ~a1;
    bus.req_raddr2 = ~a2;
    ea1 = (VERIFY && wr) ? wa : a1;
    ea2 = (VERIFY && wr) ? wa : a2;
    bus_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 40) begin
      if (rf_wa !== wa || rf_wd !== wd || rf_a1 !== ea1 || rf_a2 !== ea2) bus_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("rf_bus_hold", {31'd0, bus_ok}, 32'd1);
    check(wr ? "write_latency" : "read_latency", n, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;               // must be ignored while busy
      bus.req_wr    = 1'b1;
      bus.req_waddr = wa + 4'd1;
      @(negedge clk);
      check("req_ready_low_in_resp", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;                     // response handshake edge
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    #1;
    check("write_strobe_cycles", we_cyc - we0, wr ? 32'd1 : 32'd0);
    check("read_strobe_cycles", re_cyc - re0, (!wr || VERIFY) ? 32'd1 : 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    int  pre;
    bit  seen;
    bit  quiet;

    rst_n      = 1'b0;
    rf_clear   = 1'b1;
    force_zero = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_waddr = '0; bus.req_wdata = '0;
    bus.req_raddr1 = '0; bus.req_raddr2 = '0; bus.rsp_ready = 1'b0;
    bus4.req_valid = 1'b0; bus4.req_wr = 1'b0; bus4.req_waddr = '0; bus4.req_wdata = '0;
    bus4.req_raddr1 = '0; bus4.req_raddr2 = '0; bus4.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 3);
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_data", {16'd0, bus.rsp_data1, bus.rsp_data2}, 32'd0);
    check("rst_strobes", {30'd0, rf_we, rf_re}, 32'd0);
    check("rst_rf_bus", {16'd0, rf_wa, rf_a1, rf_wd}, 32'd0);
    check("rst_state", {29'd0, dbg}, 32'd0);
    @(posedge clk); #1;
    rf_clear = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", {31'd0, bus.req_ready}, 32'd1);

    // Write 3 <- A5 then read 3/3
    send(1'b1, 4'd3, 8'hA5, 4'd0, 4'd0, WR_LAT, 0);
    send(1'b0, 4'd0, 8'h00, 4'd3, 4'd3, RD_LAT, 0);
    check("lit_read33_d1", {24'd0, bus.rsp_data1}, 32'hA5);
    check("lit_read33_d2", {24'd0, bus.rsp_data2}, 32'hA5);

    // Boundary registers 0 and 15
    send(1'b1, 4'd0, 8'h11, 4'd0, 4'd0, WR_LAT, 0);
    send(1'b1, 4'd15, 8'hEE, 4'd0, 4'd0, WR_LAT, 0);
    send(1'b0, 4'd0, 8'h00, 4'd0, 4'd15, RD_LAT, 0);
    check("lit_read0_15_d1", {24'd0, bus.rsp_data1}, 32'h11);
    check("lit_read0_15_d2", {24'd0, bus.rsp_data2}, 32'hEE);

    // Response back-pressure for 10 cycles, stray request ignored
    send(1'b0, 4'd0, 8'h00, 4'd15, 4'd0, RD_LAT, 10);

    // More patterns, including an untouched register (init value 0x18)
    send(1'b1, 4'd5, 8'h3C, 4'd0, 4'd0, WR_LAT, 2);
    send(1'b0, 4'd0, 8'h00, 4'd5, 4'd3, RD_LAT, 0);
    send(1'b0, 4'd0, 8'h00, 4'd8, 4'd5, RD_LAT, 0);
    check("lit_read_init8", {24'd0, bus.rsp_data1}, 32'h18);

    // Reset while the write strobe is high
    n = 0;
    while (!bus.req_ready && n < 40) begin @(posedge clk); #1; n++; end
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_waddr = 4'd3; bus.req_wdata = 8'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rf_we && n < 20) begin @(negedge clk); n++; end
    check("strobe_seen_before_reset", {31'd0, rf_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_strobe_fall", {31'd0, rf_we}, 32'd0);
    check("async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("async_rf_bus", {24'd0, rf_wa, rf_wd[3:0]}, 32'd0);
    check("async_state", {29'd0, dbg}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid || rf_we) quiet = 1'b0;
    end
    check("aborted_no_response", {31'd0, quiet}, 32'd1);
    check("rf_untouched_by_abort", {24'd0, rf_mem[3]}, 32'hA5);
    check("rsp_data_cleared", {16'd0, bus.rsp_data1, bus.rsp_data2}, 32'd0);

    // After reset: write (data retained) and read of aborted target
    send(1'b1, 4'd9, 8'h77, 4'd0, 4'd0, WR_LAT, 0);
    send(1'b0, 4'd0, 8'h00, 4'd3, 4'd9, RD_LAT, 1);
    check("lit_read_after_abort", {24'd0, bus.rsp_data1}, 32'hA5);

    // SETUP_CYCLES = 4 instance: read 0/15
    n = 0;
    while (!bus4.req_ready && n < 40) begin @(posedge clk); #1; n++; end
    bus4.req_valid = 1'b1; bus4.req_wr = 1'b0; bus4.req_raddr1 = 4'd0; bus4.req_raddr2 = 4'd15;
    @(posedge clk); #1;
    bus4.req_valid = 1'b0; bus4.req_raddr1 = 4'd7; bus4.req_raddr2 = 4'd7;
    n = 0; pre = 0; seen = 1'b0;
    @(negedge clk);
    while (!bus4.rsp_valid && n < 40) begin
      if (rf_re4) seen = 1'b1;
      else if (!seen && rf_a1_4 == 4'd0 && rf_a2_4 == 4'd15) pre++;
      @(negedge clk);
      n++;
    end
    check("s4_addr_stable_cycles", pre, 32'd4);
    check("s4_read_latency", n, 32'd8);
    check("s4_d1", {24'd0, bus4.rsp_data1}, {24'd0, exp_mem[0]});
    check("s4_d2", {24'd0, bus4.rsp_data2}, 32'hEE);
    @(posedge clk); #1;
    bus4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus4.rsp_ready = 1'b0;
    @(negedge clk);
    check("s4_rsp_drop", {31'd0, bus4.rsp_valid}, 32'd0);

`ifdef RFC_WRITE_VERIFY_EN
    // Read-back verification: good write, then register file reads 0
    send(1'b1, 4'd7, 8'h5A, 4'd0, 4'd0, WR_LAT, 0);
    check("lit_verify_ok_err", {31'd0, bus.rsp_err}, 32'd0);
    force_zero = 1'b1;
    send(1'b1, 4'd7, 8'h5A, 4'd0, 4'd0, WR_LAT, 0);
    force_zero = 1'b0;
    check("lit_verify_bad_err", {31'd0, bus.rsp_err}, 32'd1);
    check("lit_verify_bad_d1", {24'd0, bus.rsp_data1}, 32'h00);
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("dut4_never_wrote", we4_cyc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
